// File: rtl/reg_bank_8.sv
// reg_bank_8: eight 8-bit general registers with one write port and one
// increment/decrement step port. R7 doubles as the stack pointer and comes out
// of reset at the top of data memory. All outputs come straight from flops.
module reg_bank_8 #(
   parameter logic [7:0] RESET_VAL = 8'h00,
   parameter logic [7:0] R7_RESET  = 8'hFF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       we,
   input  logic [2:0] wsel,
   input  logic [7:0] wdata,
   input  logic       step_en,
   input  logic [2:0] step_sel,
   input  logic       step_dir,
   output logic [7:0] r0,
   output logic [7:0] r1,
   output logic [7:0] r2,
   output logic [7:0] r3,
   output logic [7:0] r4,
   output logic [7:0] r5,
   output logic [7:0] r6,
   output logic [7:0] r7,
   output logic       wrap,
   output logic       zero
);

   logic [7:0] regs_q [8];
   logic [7:0] regs_d [8];
   logic       wrap_q;
   logic       wrap_d;
   logic       zero_q;
   logic       zero_d;
   logic [7:0] stepSrc;
   logic [7:0] stepRes;
   logic       stepDiscard;

   // Next-state: apply the step to its register unless a write to the same
   // index collides (write wins), then apply the write; status pulses only
   // for a step that actually took effect.
   always_comb begin
      regs_d      = regs_q;
      wrap_d      = 1'b0;
      zero_d      = 1'b0;
      stepSrc     = regs_q[step_sel];
      stepRes     = step_dir ? (stepSrc - 8'd1) : (stepSrc + 8'd1);
      stepDiscard = we && (wsel == step_sel);
      if (step_en && !stepDiscard) begin
         regs_d[step_sel] = stepRes;
         wrap_d           = step_dir ? (stepSrc == 8'h00) : (stepSrc == 8'hFF);
         zero_d           = (stepRes == 8'h00);
      end
      if (we) begin
         regs_d[wsel] = wdata;
      end
   end

   // State registers with synchronous reset; any write or step presented in a
   // reset cycle is dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 7; i++) begin
            regs_q[i] <= RESET_VAL;
         end
         regs_q[7] <= R7_RESET;
         wrap_q    <= 1'b0;
         zero_q    <= 1'b0;
      end else begin
         regs_q <= regs_d;
         wrap_q <= wrap_d;
         zero_q <= zero_d;
      end
   end

   assign r0   = regs_q[0];
   assign r1   = regs_q[1];
   assign r2   = regs_q[2];
   assign r3   = regs_q[3];
   assign r4   = regs_q[4];
   assign r5   = regs_q[5];
   assign r6   = regs_q[6];
   assign r7   = regs_q[7];
   assign wrap = wrap_q;
   assign zero = zero_q;

endmodule

// File: tb/tb_reg_bank_8.sv
// tb_reg_bank_8: scoreboard bench for reg_bank_8. The driver computes the
// expected register file after every edge from an integer model and queues
// it; a monitor pops one entry per cycle and compares all outputs.
module tb_reg_bank_8;

   typedef struct packed {
      logic [7:0][7:0] regs;
      logic            wrap;
      logic            zero;
   } expT;

   logic       clk;
   logic       rst;
   logic       we;
   logic [2:0] wsel;
   logic [7:0] wdata;
   logic       step_en;
   logic [2:0] step_sel;
   logic       step_dir;
   logic [7:0] r0, r1, r2, r3, r4, r5, r6, r7;
   logic       wrap;
   logic       zero;

   int  checks   = 0;
   int  failures = 0;
   int  model [8];
   bit  mWrap;
   bit  mZero;
   expT sb [$];

   reg_bank_8 #(
      .RESET_VAL(8'h00),
      .R7_RESET (8'hFF)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .we      (we),
      .wsel    (wsel),
      .wdata   (wdata),
      .step_en (step_en),
      .step_sel(step_sel),
      .step_dir(step_dir),
      .r0      (r0),
      .r1      (r1),
      .r2      (r2),
      .r3      (r3),
      .r4      (r4),
      .r5      (r5),
      .r6      (r6),
      .r7      (r7),
      .wrap    (wrap),
      .zero    (zero)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: registers as plain integers, a step is an add of +1 or
   // -1 and anything that leaves 0..255 counts as a wrap.
   task automatic modelApply(input bit rstV, input bit weV, input int wselV,
                             input int wdataV, input bit stepEnV,
                             input int stepSelV, input bit stepDirV);
      int sum;
      mWrap = 0;
      mZero = 0;
      if (rstV) begin
         for (int i = 0; i < 7; i++) model[i] = 0;
         model[7] = 255;
      end else begin
         if (stepEnV && !(weV && wselV == stepSelV)) begin
            sum             = model[stepSelV] + (stepDirV ? -1 : 1);
            mWrap           = (sum < 0) || (sum > 255);
            model[stepSelV] = (sum + 256) % 256;
            mZero           = (model[stepSelV] == 0);
         end
         if (weV) model[wselV] = wdataV;
      end
   endtask

   // Drive one cycle of inputs, let the DUT sample them, and queue the
   // outputs the model says should appear after that edge.
   task automatic applyStimulus(input bit rstV, input bit weV, input int wselV,
                                input int wdataV, input bit stepEnV,
                                input int stepSelV, input bit stepDirV);
      expT e;
      rst      = rstV;
      we       = weV;
      wsel     = 3'(wselV);
      wdata    = 8'(wdataV);
      step_en  = stepEnV;
      step_sel = 3'(stepSelV);
      step_dir = stepDirV;
      modelApply(rstV, weV, wselV, wdataV, stepEnV, stepSelV, stepDirV);
      @(posedge clk);
      for (int i = 0; i < 8; i++) e.regs[i] = 8'(model[i]);
      e.wrap = mWrap;
      e.zero = mZero;
      sb.push_back(e);
      #1;
   endtask

   task automatic idle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
   endtask

   // Directed check of one output against a constant taken from the test plan.
   task automatic checkOutput(input string name, input logic [7:0] act,
                              input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: once per cycle, away from the rising edge, pop the oldest
   // expectation and compare every output against it.
   initial begin
      expT        e;
      logic [7:0] act [8];
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e      = sb.pop_front();
            act[0] = r0; act[1] = r1; act[2] = r2; act[3] = r3;
            act[4] = r4; act[5] = r5; act[6] = r6; act[7] = r7;
            for (int i = 0; i < 8; i++) begin
               checks++;
               if (act[i] !== e.regs[i]) begin
                  failures++;
                  $display("[TB] FAIL sb_r%0d at %0t: got %h expected %h",
                           i, $time, act[i], e.regs[i]);
               end
            end
            checks++;
            if (wrap !== e.wrap) begin
               failures++;
               $display("[TB] FAIL sb_wrap at %0t: got %b expected %b", $time, wrap, e.wrap);
            end
            checks++;
            if (zero !== e.zero) begin
               failures++;
               $display("[TB] FAIL sb_zero at %0t: got %b expected %b", $time, zero, e.zero);
            end
         end
      end
   end

   // Main stimulus: test-plan sequences with constant spot checks, then a
   // randomized run checked only through the scoreboard.
   initial begin
      int wv;
      int pick;
      rst = 1'b1; we = 1'b0; wsel = '0; wdata = '0;
      step_en = 1'b0; step_sel = '0; step_dir = 1'b0;
      for (int i = 0; i < 8; i++) model[i] = 0;

      $display("[TB] reset values");
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      idle();
      @(negedge clk);
      checkOutput("rst_r0", r0, 8'h00);
      checkOutput("rst_r6", r6, 8'h00);
      checkOutput("rst_r7", r7, 8'hFF);
      checkOutput("rst_wrapzero", {6'b0, wrap, zero}, 8'h00);

      $display("[TB] write and read-back");
      applyStimulus(0, 1, 3, 8'hA5, 0, 0, 0);
      @(negedge clk);
      checkOutput("wr_r3", r3, 8'hA5);
      checkOutput("wr_r2_untouched", r2, 8'h00);
      applyStimulus(0, 1, 0, 8'h3C, 0, 0, 0);
      @(negedge clk);
      checkOutput("wr_r0", r0, 8'h3C);

      $display("[TB] increment wrap");
      applyStimulus(0, 1, 2, 8'hFE, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 1, 2, 0);
      @(negedge clk);
      checkOutput("inc1_r2", r2, 8'hFF);
      checkOutput("inc1_wz", {6'b0, wrap, zero}, 8'h00);
      applyStimulus(0, 0, 0, 0, 1, 2, 0);
      @(negedge clk);
      checkOutput("inc2_r2", r2, 8'h00);
      checkOutput("inc2_wz", {6'b0, wrap, zero}, 8'h03);
      idle();
      @(negedge clk);
      checkOutput("inc_pulse_clear", {6'b0, wrap, zero}, 8'h00);

      $display("[TB] stack pointer decrement");
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 1, 7, 1);
      @(negedge clk);
      checkOutput("sp_dec1", r7, 8'hFE);
      applyStimulus(0, 0, 0, 0, 1, 7, 1);
      @(negedge clk);
      checkOutput("sp_dec2", r7, 8'hFD);
      applyStimulus(0, 0, 0, 0, 1, 7, 1);
      @(negedge clk);
      checkOutput("sp_dec3", r7, 8'hFC);
      applyStimulus(0, 1, 7, 8'h01, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 1, 7, 1);
      @(negedge clk);
      checkOutput("sp_to_zero", r7, 8'h00);
      checkOutput("sp_to_zero_wz", {6'b0, wrap, zero}, 8'h01);
      applyStimulus(0, 0, 0, 0, 1, 7, 1);
      @(negedge clk);
      checkOutput("sp_wrap", r7, 8'hFF);
      checkOutput("sp_wrap_wz", {6'b0, wrap, zero}, 8'h02);

      $display("[TB] collisions");
      applyStimulus(0, 1, 5, 8'h10, 1, 5, 0);
      @(negedge clk);
      checkOutput("coll_same_r5", r5, 8'h10);
      checkOutput("coll_same_wz", {6'b0, wrap, zero}, 8'h00);
      applyStimulus(0, 1, 4, 8'hFF, 0, 0, 0);
      applyStimulus(0, 1, 1, 8'h77, 1, 4, 0);
      @(negedge clk);
      checkOutput("coll_diff_r1", r1, 8'h77);
      checkOutput("coll_diff_r4", r4, 8'h00);
      checkOutput("coll_diff_wz", {6'b0, wrap, zero}, 8'h03);

      $display("[TB] reset mid-operation");
      applyStimulus(1, 1, 6, 8'h55, 1, 7, 1);
      @(negedge clk);
      checkOutput("rstmid_r6", r6, 8'h00);
      checkOutput("rstmid_r7", r7, 8'hFF);
      applyStimulus(0, 1, 6, 8'h42, 0, 0, 0);
      @(negedge clk);
      checkOutput("rstmid_resume_r6", r6, 8'h42);

      $display("[TB] randomized traffic");
      for (int n = 0; n < 400; n++) begin
         pick = int'($urandom_range(0, 4));
         case (pick)
            0: wv = 8'h00;
            1: wv = 8'hFF;
            2: wv = 8'h01;
            3: wv = 8'hFE;
            default: wv = int'($urandom_range(0, 255));
         endcase
         applyStimulus(($urandom_range(0, 31) == 0),
                       bit'($urandom_range(0, 1)),
                       int'($urandom_range(0, 7)), wv,
                       bit'($urandom_range(0, 1)),
                       int'($urandom_range(0, 7)),
                       bit'($urandom_range(0, 1)));
      end
      idle();

      for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
      @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("[TB] FAIL drain: got %0d pending expected 0", sb.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
